// File: rtl/fetch_decode_queue.sv
// Instruction queue between the frontend and decode: a circular buffer of
// {misaligned, pc, instr} entries with flush, backpressure and a sticky drop flag.
module fetch_decode_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0033,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          fe_valid,
  input  logic [31:0]   fe_pc,
  input  logic [31:0]   fe_instr,
  input  logic          fe_misaligned,
  output logic          fe_ready,
  input  logic          flush,
  output logic          de_valid,
  output logic [31:0]   de_pc,
  output logic [31:0]   de_instr,
  output logic          de_misaligned,
  input  logic          de_ready,
  output logic [AW:0]   q_count,
  output logic          drop_err
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [64:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [64:0]   head;
  logic          push;
  logic          pop;

  assign fe_ready = (count != FULL_CNT);
  assign de_valid = (count != '0);
  assign push     = fe_valid & fe_ready & ~flush;
  assign pop      = de_valid & de_ready & ~flush;
  assign q_count  = count;

  // Flush equalises the pointers rather than zeroing them; storage is untouched.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      drop_err <= 1'b0;
    end else if (fe_valid & ~fe_ready & ~flush) begin
      drop_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {fe_misaligned, fe_pc, fe_instr};
  end

  assign head = mem[rd_ptr];

  always_comb begin
    de_pc         = 32'h0;
    de_instr      = NOP_INSTR;
    de_misaligned = 1'b0;
    if (de_valid) begin
      de_misaligned = head[64];
      de_pc         = head[63:32];
      de_instr      = head[31:0];
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        nrst;
  logic        fe_valid;
  logic [31:0] fe_pc;
  logic [31:0] fe_instr;
  logic        fe_misaligned;
  logic        fe_ready;
  logic        flush;
  logic        de_valid;
  logic [31:0] de_pc;
  logic [31:0] de_instr;
  logic        de_misaligned;
  logic        de_ready;
  logic [2:0]  q_count;
  logic        drop_err;

  int total = 0;
  int bad   = 0;

  fetch_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .nrst(nrst),
    .fe_valid(fe_valid), .fe_pc(fe_pc), .fe_instr(fe_instr),
    .fe_misaligned(fe_misaligned), .fe_ready(fe_ready),
    .flush(flush),
    .de_valid(de_valid), .de_pc(de_pc), .de_instr(de_instr),
    .de_misaligned(de_misaligned), .de_ready(de_ready),
    .q_count(q_count), .drop_err(drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of entries plus the sticky drop flag.
  logic [64:0] mq[$];
  bit          mdrop;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mq.delete();
      mdrop = 1'b0;
    end else if (flush) begin
      mq.delete();
    end else begin
      bit was_full;
      was_full = (mq.size() == DEPTH);
      if (fe_valid && was_full) mdrop = 1'b1;
      if (de_ready && mq.size() != 0) void'(mq.pop_front());
      if (fe_valid && !was_full) mq.push_back({fe_misaligned, fe_pc, fe_instr});
    end
  end

  always @(negedge clk) begin
    if (nrst) begin
      int n;
      n = mq.size();
      chk("m_de_valid", 64'(de_valid), 64'(n != 0));
      chk("m_fe_ready", 64'(fe_ready), 64'(n != DEPTH));
      chk("m_q_count",  64'(q_count),  64'(n));
      chk("m_drop_err", 64'(drop_err), 64'(mdrop));
      if (n != 0) begin
        chk("m_de_pc",    64'(de_pc),         64'(mq[0][63:32]));
        chk("m_de_instr", 64'(de_instr),      64'(mq[0][31:0]));
        chk("m_de_mis",   64'(de_misaligned), 64'(mq[0][64]));
      end else begin
        chk("m_de_pc",    64'(de_pc),         64'h0);
        chk("m_de_instr", 64'(de_instr),      64'h33);
        chk("m_de_mis",   64'(de_misaligned), 64'h0);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic mis, input logic rdy, input logic fl);
    fe_valid      = v;
    fe_pc         = pc;
    fe_instr      = ins;
    fe_misaligned = mis;
    de_ready      = rdy;
    flush         = fl;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    nrst = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_de_valid", 64'(de_valid), 64'h0);
    chk("rst_de_instr", 64'(de_instr), 64'h33);
    chk("rst_fe_ready", 64'(fe_ready), 64'h1);
    chk("rst_q_count",  64'(q_count),  64'h0);
    #2 nrst = 1'b1;
    @(negedge clk);

    // fill to full, overflow, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h4000_0000 + 32'(4 * i), 32'h0010_0093 + 32'(i), 0, 0, 0);
      cyc();
    end
    chk("full_q_count",  64'(q_count),  64'h4);
    chk("full_fe_ready", 64'(fe_ready), 64'h0);
    drive(1, 32'h4000_0010, 32'h0000_0013, 0, 0, 0);
    cyc();
    chk("ovf_drop_err", 64'(drop_err), 64'h1);
    chk("ovf_q_count",  64'(q_count),  64'h4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", 64'(de_pc), 64'(32'h4000_0000 + 32'(4 * i)));
      drive(0, 32'h0, 32'h0, 0, 1, 0);
      cyc();
    end
    chk("drain_q_count", 64'(q_count), 64'h0);

    // async reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h4000_0040 + 32'(4 * i), 32'h0000_0013, 0, 0, 0);
      cyc();
    end
    chk("pre_rst_q_count", 64'(q_count), 64'h3);
    #2 nrst = 1'b0;
    #1;
    chk("arst_de_valid", 64'(de_valid), 64'h0);
    chk("arst_de_instr", 64'(de_instr), 64'h33);
    chk("arst_fe_ready", 64'(fe_ready), 64'h1);
    chk("arst_q_count",  64'(q_count),  64'h0);
    chk("arst_drop_err", 64'(drop_err), 64'h0);
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    @(negedge clk);
    #2 nrst = 1'b1;
    @(negedge clk);

    drive(1, 32'h4000_0000, 32'h0000_0513, 0, 0, 0);
    #1;
    chk("nobypass_de_valid", 64'(de_valid), 64'h0);
    cyc();
    chk("first_de_valid", 64'(de_valid), 64'h1);
    chk("first_de_pc",    64'(de_pc),    64'h4000_0000);
    chk("first_de_instr", 64'(de_instr), 64'h0000_0513);

    // simultaneous push/pop at count 2 across pointer wrap
    drive(1, 32'h4000_0004, 32'h0000_0013, 0, 0, 0);
    cyc();
    for (int k = 0; k < 10; k++) begin
      chk("sim_q_count", 64'(q_count), 64'h2);
      chk("sim_de_pc",   64'(de_pc),   64'(32'h4000_0000 + 32'(4 * k)));
      drive(1, 32'h4000_0008 + 32'(4 * k), 32'h0000_0013, 0, 1, 0);
      cyc();
    end
    chk("sim_end_q_count", 64'(q_count), 64'h2);
    chk("sim_end_de_pc",   64'(de_pc),   64'h4000_0028);

    // flush beats a simultaneous push and pop
    drive(1, 32'h4000_0030, 32'h0000_0013, 0, 0, 0);
    cyc();
    chk("pre_flush_q_count", 64'(q_count), 64'h3);
    drive(1, 32'h4000_0100, 32'h0000_0013, 0, 1, 1);
    cyc();
    chk("flush_q_count",  64'(q_count),  64'h0);
    chk("flush_de_valid", 64'(de_valid), 64'h0);
    drive(1, 32'h4000_0200, 32'h0000_0013, 0, 0, 0);
    cyc();
    chk("post_flush_de_valid", 64'(de_valid), 64'h1);
    chk("post_flush_de_pc",    64'(de_pc),    64'h4000_0200);
    chk("post_flush_q_count",  64'(q_count),  64'h1);
    drive(0, 32'h0, 32'h0, 0, 1, 0);
    cyc();

    // bubbles: NOP presented while empty
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("empty_de_valid", 64'(de_valid), 64'h0);
      chk("empty_de_instr", 64'(de_instr), 64'h33);
      chk("empty_de_pc",    64'(de_pc),    64'h0);
      chk("empty_q_count",  64'(q_count),  64'h0);
    end

    // misaligned flag follows its entry
    drive(1, 32'h4000_0003, 32'h0000_0013, 1, 0, 0);
    cyc();
    drive(1, 32'h4000_0004, 32'h0000_0013, 0, 0, 0);
    cyc();
    chk("mis_head_flag", 64'(de_misaligned), 64'h1);
    chk("mis_head_pc",   64'(de_pc),         64'h4000_0003);
    drive(0, 32'h0, 32'h0, 0, 1, 0);
    cyc();
    chk("mis_next_flag", 64'(de_misaligned), 64'h0);
    chk("mis_next_pc",   64'(de_pc),         64'h4000_0004);
    cyc();
    chk("mis_empty_flag",  64'(de_misaligned), 64'h0);
    chk("mis_empty_valid", 64'(de_valid),      64'h0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
      cyc();
    end
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
